// File: rtl/udm_uart_rx.sv
// UDM debug-channel UART receiver: 2-flop synchronized 8N1 deframer with 4-entry FWFT valid/ready FIFO.
// Byte visible the cycle after the stop-bit sample; a full FIFO without a pop drops the byte and sets sticky overflow.
module udm_uart_rx #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             frame_err_o,
  output logic             overflow_o,
  input  logic             err_clr_i,
  output logic             busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_eff, div_eff_nxt, div_clamp;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             push, bad_stop;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             pop, full, wr_en, ovf_set;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign div_clamp = (div_i < DIV_MIN) ? DIV_MIN : div_i;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_eff_nxt = div_eff;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    push        = 1'b0;
    bad_stop    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          div_eff_nxt = div_clamp;
          cnt_nxt     = (div_clamp >> 1) - ONE;
          state_nxt   = START;
        end
      end
      START: begin
        cnt_nxt = cnt - ONE;
        if (cnt == '0) begin
          // A start bit that is high again at mid-bit is a line glitch.
          if (!rx_s) begin
            cnt_nxt     = div_eff - ONE;
            bit_idx_nxt = 3'd0;
            state_nxt   = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        cnt_nxt = cnt - ONE;
        if (cnt == '0) begin
          shift_nxt   = {rx_s, shift_reg[7:1]};
          cnt_nxt     = div_eff - ONE;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_nxt = cnt - ONE;
        if (cnt == '0) begin
          push      = rx_s;
          bad_stop  = !rx_s;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      cnt         <= '0;
      div_eff     <= DIV_MIN;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'h00;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      div_eff     <= div_eff_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_nxt;
      frame_err_o <= bad_stop;
    end
  end

  assign busy_o = (state != IDLE);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_valid_o = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign pop        = rx_valid_o & rx_ready_i;
  assign wr_en      = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;
  assign rx_data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= shift_reg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)        overflow_o <= 1'b1;
      else if (err_clr_i) overflow_o <= 1'b0;
    end
  end

endmodule
